// File: rtl/llc_set_reader.sv
// LLC set reader: fetches every way's tag/state of one set from a grouped
// tag/state memory, assembles the full set, and reports the lowest matching
// valid way and the lowest INVALID way to a downstream consumer.
module llc_set_reader #(
    parameter int LLC_WAYS   = 16,
    parameter int GRP_WAYS   = 4,
    parameter int SET_BITS   = 9,
    parameter int TAG_BITS   = 12,
    parameter int STATE_BITS = 3,
    parameter int RD_LAT     = 2,
    localparam int NG        = LLC_WAYS / GRP_WAYS,
    localparam int GRP_W     = (NG > 1) ? $clog2(NG) : 1,
    localparam int WAY_W     = (LLC_WAYS > 1) ? $clog2(LLC_WAYS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [SET_BITS-1:0]            in_set,
    input  logic [TAG_BITS-1:0]            in_tag,
    input  logic                           in_look,
    output logic                           mem_rd_en,
    output logic [SET_BITS-1:0]            mem_rd_set,
    output logic [GRP_W-1:0]               mem_rd_grp,
    input  logic [GRP_WAYS*TAG_BITS-1:0]   mem_rd_tags,
    input  logic [GRP_WAYS*STATE_BITS-1:0] mem_rd_states,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SET_BITS-1:0]            out_set,
    output logic [TAG_BITS-1:0]            out_tag,
    output logic [LLC_WAYS*TAG_BITS-1:0]   out_tags,
    output logic [LLC_WAYS*STATE_BITS-1:0] out_states,
    output logic                           out_hit,
    output logic [WAY_W-1:0]               out_hit_way,
    output logic                           out_empty_valid,
    output logic [WAY_W-1:0]               out_empty_way,
    output logic                           busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                          state_q;
    logic [GRP_W-1:0]                grp_q;
    logic                            rd_en_q;
    logic [RD_LAT-1:0]               dl_vld_q;
    logic [GRP_W-1:0]                dl_grp_q [RD_LAT];
    logic [SET_BITS-1:0]             set_q;
    logic [TAG_BITS-1:0]             tag_q;
    logic [LLC_WAYS*TAG_BITS-1:0]    tags_q;
    logic [LLC_WAYS*STATE_BITS-1:0]  states_q;
    logic                            hit_q;
    logic [WAY_W-1:0]                hit_way_q;
    logic                            empty_valid_q;
    logic [WAY_W-1:0]                empty_way_q;

    logic                            cap_vld_s;
    logic [GRP_W-1:0]                cap_grp_s;
    logic                            cap_last_s;
    logic [LLC_WAYS*TAG_BITS-1:0]    tags_nxt_s;
    logic [LLC_WAYS*STATE_BITS-1:0]  states_nxt_s;
    logic [WAY_W:0]                  hit_s;
    logic [WAY_W:0]                  empty_s;

    // Lowest way whose state is not INVALID and whose tag matches; MSB = found.
    function automatic logic [WAY_W:0] find_hit(
        input logic [LLC_WAYS*TAG_BITS-1:0]   tags,
        input logic [LLC_WAYS*STATE_BITS-1:0] states,
        input logic [TAG_BITS-1:0]            tag
    );
        logic [WAY_W:0] r;
        r = '0;
        for (int w = LLC_WAYS - 1; w >= 0; w--) begin
            r = ((states[w*STATE_BITS +: STATE_BITS] != '0) &&
                 (tags[w*TAG_BITS +: TAG_BITS] == tag)) ? {1'b1, WAY_W'(w)} : r;
        end
        return r;
    endfunction

    // Lowest way whose state is INVALID; MSB = found.
    function automatic logic [WAY_W:0] find_empty(
        input logic [LLC_WAYS*STATE_BITS-1:0] states
    );
        logic [WAY_W:0] r;
        r = '0;
        for (int w = LLC_WAYS - 1; w >= 0; w--) begin
            r = (states[w*STATE_BITS +: STATE_BITS] == '0) ? {1'b1, WAY_W'(w)} : r;
        end
        return r;
    endfunction

    // Merge the group emerging from the delay line into the way slots and
    // evaluate hit/empty on the merged view so the results can be registered
    // on the same edge that captures the last group.
    always_comb begin
        cap_vld_s    = dl_vld_q[RD_LAT-1];
        cap_grp_s    = dl_grp_q[RD_LAT-1];
        cap_last_s   = cap_vld_s && (cap_grp_s == GRP_W'(NG - 1));
        tags_nxt_s   = tags_q;
        states_nxt_s = states_q;
        for (int g = 0; g < NG; g++) begin
            tags_nxt_s[g*GRP_WAYS*TAG_BITS +: GRP_WAYS*TAG_BITS] =
                (cap_vld_s && (cap_grp_s == GRP_W'(g))) ? mem_rd_tags
                : tags_q[g*GRP_WAYS*TAG_BITS +: GRP_WAYS*TAG_BITS];
            states_nxt_s[g*GRP_WAYS*STATE_BITS +: GRP_WAYS*STATE_BITS] =
                (cap_vld_s && (cap_grp_s == GRP_W'(g))) ? mem_rd_states
                : states_q[g*GRP_WAYS*STATE_BITS +: GRP_WAYS*STATE_BITS];
        end
        hit_s   = find_hit(tags_nxt_s, states_nxt_s, tag_q);
        empty_s = find_empty(states_nxt_s);
    end

    // Read-latency delay line tracking which group each strobe returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dl_grp_q[i] <= '0;
            end
        end else begin
            dl_vld_q[0] <= rd_en_q;
            dl_grp_q[0] <= grp_q;
            for (int i = 1; i < RD_LAT; i++) begin
                dl_vld_q[i] <= dl_vld_q[i-1];
                dl_grp_q[i] <= dl_grp_q[i-1];
            end
        end
    end

    // Request FSM with its registered read strobe and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grp_q         <= '0;
            rd_en_q       <= 1'b0;
            set_q         <= '0;
            tag_q         <= '0;
            tags_q        <= '0;
            states_q      <= '0;
            hit_q         <= 1'b0;
            hit_way_q     <= '0;
            empty_valid_q <= 1'b0;
            empty_way_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        set_q         <= in_set;
                        tag_q         <= in_tag;
                        tags_q        <= '0;
                        states_q      <= '0;
                        hit_q         <= 1'b0;
                        hit_way_q     <= '0;
                        empty_valid_q <= 1'b0;
                        empty_way_q   <= '0;
                        grp_q         <= '0;
                        if (in_look) begin
                            state_q <= ISSUE;
                            rd_en_q <= 1'b1;
                        end else begin
                            state_q <= HOLD;
                        end
                    end
                end
                ISSUE: begin
                    tags_q   <= tags_nxt_s;
                    states_q <= states_nxt_s;
                    if (grp_q == GRP_W'(NG - 1)) begin
                        rd_en_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        grp_q <= grp_q + GRP_W'(1);
                    end
                end
                DRAIN: begin
                    tags_q   <= tags_nxt_s;
                    states_q <= states_nxt_s;
                    if (cap_last_s) begin
                        hit_q         <= hit_s[WAY_W];
                        hit_way_q     <= hit_s[WAY_W-1:0];
                        empty_valid_q <= empty_s[WAY_W];
                        empty_way_q   <= empty_s[WAY_W-1:0];
                        state_q       <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready        = (state_q == IDLE) && !rst;
    assign busy            = (state_q != IDLE);
    assign out_valid       = (state_q == HOLD);
    assign mem_rd_en       = rd_en_q;
    assign mem_rd_set      = set_q;
    assign mem_rd_grp      = grp_q;
    assign out_set         = set_q;
    assign out_tag         = tag_q;
    assign out_tags        = tags_q;
    assign out_states      = states_q;
    assign out_hit         = hit_q;
    assign out_hit_way     = hit_way_q;
    assign out_empty_valid = empty_valid_q;
    assign out_empty_way   = empty_way_q;

endmodule

// File: tb/tb_llc_set_reader.sv
// Self-checking bench for llc_set_reader: a memory responder with RD_LAT=2
// and a set-level reference model computing expected outputs directly.
module tb_llc_set_reader;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_look, out_ready;
    logic          in_ready, mem_rd_en, out_valid, out_hit, out_empty_valid, busy;
    logic [8:0]    in_set, mem_rd_set, out_set;
    logic [11:0]   in_tag, out_tag;
    logic [1:0]    mem_rd_grp;
    logic [47:0]   mem_rd_tags;
    logic [11:0]   mem_rd_states;
    logic [191:0]  out_tags;
    logic [47:0]   out_states;
    logic [3:0]    out_hit_way, out_empty_way;

    int checks = 0;
    int failures = 0;

    logic [11:0] m_tag [512][16];
    logic [2:0]  m_st  [512][16];

    logic        d1_v, d2_v;
    logic [8:0]  d1_s, d2_s;
    logic [1:0]  d1_g, d2_g;
    logic [47:0] junk_t;
    logic [11:0] junk_s;

    logic [191:0] exp_tags;
    logic [47:0]  exp_states;
    logic         exp_hit, exp_ev;
    logic [3:0]   exp_hw, exp_ew;

    always #5 clk = ~clk;

    llc_set_reader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_set(in_set), .in_tag(in_tag), .in_look(in_look),
        .mem_rd_en(mem_rd_en), .mem_rd_set(mem_rd_set), .mem_rd_grp(mem_rd_grp),
        .mem_rd_tags(mem_rd_tags), .mem_rd_states(mem_rd_states),
        .out_valid(out_valid), .out_ready(out_ready), .out_set(out_set),
        .out_tag(out_tag), .out_tags(out_tags), .out_states(out_states),
        .out_hit(out_hit), .out_hit_way(out_hit_way),
        .out_empty_valid(out_empty_valid), .out_empty_way(out_empty_way),
        .busy(busy)
    );

    // Memory responder: data for a strobe appears two cycles later; garbage otherwise.
    always @(posedge clk) begin
        d1_v   <= mem_rd_en;  d1_s <= mem_rd_set; d1_g <= mem_rd_grp;
        d2_v   <= d1_v;       d2_s <= d1_s;       d2_g <= d1_g;
        junk_t <= {16'($urandom), 32'($urandom)};
        junk_s <= 12'($urandom);
    end

    // Drive the group's tags/states from the memory array.
    always_comb begin
        mem_rd_tags   = junk_t;
        mem_rd_states = junk_s;
        if (d2_v === 1'b1) begin
            for (int k = 0; k < 4; k++) begin
                mem_rd_tags[k*12 +: 12]  = m_tag[d2_s][int'(d2_g)*4 + k];
                mem_rd_states[k*3 +: 3]  = m_st[d2_s][int'(d2_g)*4 + k];
            end
        end
    end

    // Reference: what the consumer should see for a request to set s.
    function automatic void model(input logic [8:0] s, input logic [11:0] t, input bit lk);
        exp_tags = '0; exp_states = '0;
        exp_hit = 1'b0; exp_hw = 4'd0; exp_ev = 1'b0; exp_ew = 4'd0;
        if (lk) begin
            for (int w = 0; w < 16; w++) begin
                exp_tags[w*12 +: 12] = m_tag[s][w];
                exp_states[w*3 +: 3] = m_st[s][w];
            end
            for (int w = 15; w >= 0; w--) begin
                if (m_st[s][w] != 3'd0 && m_tag[s][w] == t) begin exp_hit = 1'b1; exp_hw = 4'(w); end
                if (m_st[s][w] == 3'd0) begin exp_ev = 1'b1; exp_ew = 4'(w); end
            end
        end
    endfunction

    // Issue one request from a negedge and wait (bounded) for out_valid.
    task automatic send_req(input logic [8:0] s, input logic [11:0] t, input bit lk,
                            output int lat, output int nstr, output int badstr);
        int g;
        g = 0;
        while (in_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
        in_valid = 1'b1; in_set = s; in_tag = t; in_look = lk;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1; nstr = 0; badstr = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (mem_rd_en === 1'b1) begin
                if (mem_rd_set !== s || mem_rd_grp !== nstr[1:0]) badstr++;
                nstr++;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    // Pulse out_ready for one edge; returns at the following negedge.
    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_look = 1'b0; in_set = '0; in_tag = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL rst_mem_rd_en got=%b exp=0", mem_rd_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if ({out_set, out_tag, out_hit, out_empty_valid, out_tags} !== '0) begin
            failures++; $display("FAIL rst_outs got set=%h tag=%h hit=%b ev=%b", out_set, out_tag, out_hit, out_empty_valid); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_default();
        int lat, nstr, bad;
        for (int w = 0; w < 16; w++) begin m_tag[5][w] = 12'(w); m_st[5][w] = 3'd0; end
        m_tag[5][6] = 12'h123; m_st[5][6] = 3'd2;
        send_req(9'h005, 12'h123, 1'b1, lat, nstr, bad);
        model(9'h005, 12'h123, 1'b1);
        checks++; if (lat != 7) begin failures++; $display("FAIL dflt_latency got=%0d exp=7", lat); end
        checks++; if (nstr != 4 || bad != 0) begin failures++; $display("FAIL dflt_strobes got=%0d bad=%0d exp=4 bad=0", nstr, bad); end
        checks++; if (out_hit !== 1'b1 || out_hit_way !== 4'd6) begin failures++; $display("FAIL dflt_hit got=%b/%0d exp=1/6", out_hit, out_hit_way); end
        checks++; if (out_empty_valid !== 1'b1 || out_empty_way !== 4'd0) begin failures++; $display("FAIL dflt_empty got=%b/%0d exp=1/0", out_empty_valid, out_empty_way); end
        checks++; if (out_tags !== exp_tags || out_states !== exp_states) begin failures++; $display("FAIL dflt_ways got=%h/%h exp=%h/%h", out_tags, out_states, exp_tags, exp_states); end
        checks++; if (out_set !== 9'h005 || out_tag !== 12'h123) begin failures++; $display("FAIL dflt_latch got=%h/%h exp=005/123", out_set, out_tag); end
        release_out();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL dflt_release got in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid); end
    endtask

    task automatic test_nolook();
        int lat, nstr, bad;
        send_req(9'h1FF, 12'hABC, 1'b0, lat, nstr, bad);
        checks++; if (lat != 1) begin failures++; $display("FAIL nolook_latency got=%0d exp=1", lat); end
        checks++; if (nstr != 0) begin failures++; $display("FAIL nolook_strobes got=%0d exp=0", nstr); end
        checks++; if (out_set !== 9'h1FF || out_hit !== 1'b0 || out_empty_valid !== 1'b0) begin
            failures++; $display("FAIL nolook_outs got set=%h hit=%b ev=%b exp=1ff/0/0", out_set, out_hit, out_empty_valid); end
        checks++; if (out_tags !== '0 || out_states !== '0) begin failures++; $display("FAIL nolook_ways got=%h/%h exp=0", out_tags, out_states); end
        release_out();
    endtask

    task automatic test_all_valid();
        int lat, nstr, bad;
        for (int w = 0; w < 16; w++) begin m_tag[9'h0AA][w] = 12'h200 + 12'(w); m_st[9'h0AA][w] = 3'($urandom_range(1, 7)); end
        m_tag[9'h0AA][3] = 12'h123; m_tag[9'h0AA][9] = 12'h123;
        send_req(9'h0AA, 12'h123, 1'b1, lat, nstr, bad);
        checks++; if (out_hit !== 1'b1 || out_hit_way !== 4'd3) begin failures++; $display("FAIL allv_hit got=%b/%0d exp=1/3", out_hit, out_hit_way); end
        checks++; if (out_empty_valid !== 1'b0 || out_empty_way !== 4'd0) begin failures++; $display("FAIL allv_empty got=%b/%0d exp=0/0", out_empty_valid, out_empty_way); end
        release_out();
    endtask

    task automatic test_invalid_match();
        int lat, nstr, bad;
        for (int w = 0; w < 16; w++) begin m_tag[9'h033][w] = 12'h400 + 12'(w); m_st[9'h033][w] = 3'($urandom_range(1, 7)); end
        m_tag[9'h033][5] = 12'h123; m_st[9'h033][5] = 3'd0;
        send_req(9'h033, 12'h123, 1'b1, lat, nstr, bad);
        checks++; if (out_hit !== 1'b0 || out_hit_way !== 4'd0) begin failures++; $display("FAIL invm_hit got=%b/%0d exp=0/0", out_hit, out_hit_way); end
        checks++; if (out_empty_valid !== 1'b1 || out_empty_way !== 4'd5) begin failures++; $display("FAIL invm_empty got=%b/%0d exp=1/5", out_empty_valid, out_empty_way); end
        release_out();
    endtask

    task automatic test_hold_stall();
        int lat, nstr, bad;
        logic [270:0] snap;
        send_req(9'h005, 12'h123, 1'b1, lat, nstr, bad);
        snap = {out_set, out_tag, out_tags, out_states, out_hit, out_hit_way, out_empty_valid, out_empty_way};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if ({out_set, out_tag, out_tags, out_states, out_hit, out_hit_way, out_empty_valid, out_empty_way} !== snap
                          || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++; $display("FAIL hold_stable cycle=%0d out_valid=%b in_ready=%b hit=%b way=%0d", i, out_valid, in_ready, out_hit, out_hit_way); end
        end
        release_out();
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL hold_release got in_ready=%b busy=%b exp=1/0", in_ready, busy); end
    endtask

    task automatic test_reset_drain();
        int lat, nstr, bad;
        in_valid = 1'b1; in_set = 9'h010; in_tag = m_tag[9'h010][0]; in_look = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (mem_rd_en !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL drain_state got rd_en=%b busy=%b exp=0/1", mem_rd_en, busy); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL drain_rst got busy=%b in_ready=%b out_valid=%b exp=0/1/0", busy, in_ready, out_valid); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0 || out_tags !== '0 || out_states !== '0) begin
                failures++; $display("FAIL drain_late_data cycle=%0d out_valid=%b tags=%h", i, out_valid, out_tags); end
        end
        for (int w = 0; w < 16; w++) begin m_tag[9'h020][w] = 12'(w); m_st[9'h020][w] = 3'($urandom_range(1, 7)); end
        m_tag[9'h020][11] = 12'h3AB; m_st[9'h020][11] = 3'd1;
        send_req(9'h020, 12'h3AB, 1'b1, lat, nstr, bad);
        model(9'h020, 12'h3AB, 1'b1);
        checks++; if (lat != 7 || out_hit !== 1'b1 || out_hit_way !== 4'd11 || out_empty_valid !== 1'b0) begin
            failures++; $display("FAIL drain_fresh got lat=%0d hit=%b way=%0d ev=%b exp=7/1/11/0", lat, out_hit, out_hit_way, out_empty_valid); end
        checks++; if (out_tags !== exp_tags || out_states !== exp_states) begin failures++; $display("FAIL drain_fresh_ways got=%h exp=%h", out_tags, exp_tags); end
        release_out();
    endtask

    task automatic test_random();
        int lat, nstr, bad;
        logic [8:0]  s;
        logic [11:0] t;
        bit          lk;
        for (int n = 0; n < 30; n++) begin
            s  = 9'($urandom_range(0, 511));
            lk = ($urandom_range(0, 3) != 0);
            t  = ($urandom_range(0, 1) == 1) ? m_tag[s][$urandom_range(0, 15)] : 12'($urandom);
            send_req(s, t, lk, lat, nstr, bad);
            model(s, t, lk);
            checks++; if (lat != (lk ? 7 : 1) || nstr != (lk ? 4 : 0) || bad != 0) begin
                failures++; $display("FAIL rnd_timing n=%0d got lat=%0d strobes=%0d bad=%0d look=%0d", n, lat, nstr, bad, lk); end
            checks++; if (out_set !== s || out_tag !== t || out_tags !== exp_tags || out_states !== exp_states) begin
                failures++; $display("FAIL rnd_ways n=%0d got set=%h tag=%h tags=%h exp set=%h tag=%h tags=%h", n, out_set, out_tag, out_tags, s, t, exp_tags); end
            checks++; if (out_hit !== exp_hit || out_hit_way !== exp_hw || out_empty_valid !== exp_ev || out_empty_way !== exp_ew) begin
                failures++; $display("FAIL rnd_lookup n=%0d got %b/%0d/%b/%0d exp %b/%0d/%b/%0d", n, out_hit, out_hit_way,
                                     out_empty_valid, out_empty_way, exp_hit, exp_hw, exp_ev, exp_ew); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            release_out();
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rnd_release n=%0d in_ready=%b exp=1", n, in_ready); end
        end
    endtask

    initial begin
        for (int s = 0; s < 512; s++) begin
            for (int w = 0; w < 16; w++) begin
                m_tag[s][w] = 12'($urandom);
                m_st[s][w]  = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            end
        end
        test_reset();
        test_default();
        test_nolook();
        test_all_valid();
        test_invalid_match();
        test_hold_stall();
        test_reset_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
